// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunked adder-subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of chunk passes needed to cover the whole operand.
    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; a single-chunk build still needs a 1-bit index.
    function automatic int calc_idx_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry-out and carry into its MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    // Zero-extended add so the top bit is the carry out of the slice.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // Carry into the MSB recovered from the MSB sum bit; also valid for CHUNK=1.
    assign c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Serial-by-chunk adder/subtractor: CHUNK bits per clock with the ripple
// carry held in a register between chunks.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; result/cout/overflow hold last values
//   RUN   | one chunk added per clock, idx selects the chunk
//   DONE  | single-cycle done pulse; start here begins a new operation
module chunked_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int NCH   = calc_nch(WIDTH, CHUNK);
    localparam int IDX_W = calc_idx_w(NCH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             c_out_chunk, c_msb_chunk;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (idx_q == IDX_LAST);

    // Select the operand chunk addressed by the current index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .sum   (sum_chunk),
        .cout  (c_out_chunk),
        .c_msb (c_msb_chunk)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE accepts start directly for back-to-back operations.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next values: latch operands on accept, add one chunk per RUN cycle.
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (accept) begin
            idx_d    = '0;
            a_d      = a;
            b_d      = sub ? ~b : b;
            carry_d  = sub ? ~cin : cin;
            result_d = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < NCH; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    result_d[i*CHUNK +: CHUNK] = sum_chunk;
                end
            end
            carry_d = c_out_chunk;
            idx_d   = idx_q + IDX_W'(1);
            if (last) begin
                cout_d = c_out_chunk;
                ovf_d  = c_out_chunk ^ c_msb_chunk;
            end
        end
    end

    // Datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed table, protocol sequences, async reset
// and a randomized parameter sweep against an arithmetic reference model.
module tb_chunked_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance k: 0=(16,4) 1=(16,16) 2=(16,1) 3=(32,8)
    logic [3:0]  start_i, sub_i, cin_i;
    logic [31:0] a_i [4];
    logic [31:0] b_i [4];
    logic [3:0]  busy_o, done_o, cout_o, ovf_o;
    logic [15:0] r0, r1, r2;
    logic [31:0] r3;

    int checks = 0;
    int errors = 0;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .sub(sub_i[0]), .cin(cin_i[0]),
        .a(a_i[0][15:0]), .b(b_i[0][15:0]), .busy(busy_o[0]), .done(done_o[0]),
        .result(r0), .cout(cout_o[0]), .overflow(ovf_o[0]));
    chunked_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .sub(sub_i[1]), .cin(cin_i[1]),
        .a(a_i[1][15:0]), .b(b_i[1][15:0]), .busy(busy_o[1]), .done(done_o[1]),
        .result(r1), .cout(cout_o[1]), .overflow(ovf_o[1]));
    chunked_addsub #(.WIDTH(16), .CHUNK(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .sub(sub_i[2]), .cin(cin_i[2]),
        .a(a_i[2][15:0]), .b(b_i[2][15:0]), .busy(busy_o[2]), .done(done_o[2]),
        .result(r2), .cout(cout_o[2]), .overflow(ovf_o[2]));
    chunked_addsub #(.WIDTH(32), .CHUNK(8)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_i[3]), .sub(sub_i[3]), .cin(cin_i[3]),
        .a(a_i[3]), .b(b_i[3]), .busy(busy_o[3]), .done(done_o[3]),
        .result(r3), .cout(cout_o[3]), .overflow(ovf_o[3]));

    function automatic int width_of(input int k);
        return (k == 3) ? 32 : 16;
    endfunction

    function automatic int nch_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int k);
        return (k == 3) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] get_res(input int k);
        case (k)
            0:       return {16'h0, r0};
            1:       return {16'h0, r1};
            2:       return {16'h0, r2};
            default: return r3;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed readings.
    function automatic void model(input int w, input bit s, input bit c,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit co, output bit ov);
        longint m, ua, ub, sa, sb, d, ss, cc;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        cc = c ? 1 : 0;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!s) begin
            d  = ua + ub + cc;
            co = (d >= m);
            ss = sa + sb + cc;
        end else begin
            d  = ua - ub - cc;
            co = (d >= 0);
            ss = sa - sb - cc;
        end
        r  = 32'(((d % m) + m) % m);
        ov = (ss >= m / 2) || (ss < -(m / 2));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at a negedge. Returns at the negedge where done is seen (or timeout).
    // mode 1: pulse start with scrambled operands mid-run; mode 2: scramble only.
    task automatic run_op(input int k, input bit s, input bit c,
                          input logic [31:0] a, input logic [31:0] b, input int mode,
                          output logic [31:0] r, output bit co, output bit ov,
                          output int lat, output bit busy_ok);
        sub_i[k]   = s;
        cin_i[k]   = c;
        a_i[k]     = a & mask_of(k);
        b_i[k]     = b & mask_of(k);
        start_i[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i[k] = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done_o[k] && lat < 64) begin
            if (!busy_o[k]) busy_ok = 1'b0;
            if (lat == 1 && mode != 0) begin
                a_i[k]   = ~a & mask_of(k);
                b_i[k]   = (a ^ 32'h5A5A_A5A5) & mask_of(k);
                sub_i[k] = ~s;
                cin_i[k] = ~c;
                if (mode == 1) start_i[k] = 1'b1;
            end
            @(negedge clk);
            lat++;
            start_i[k] = 1'b0;
        end
        if (busy_o[k]) busy_ok = 1'b0;
        r  = get_res(k);
        co = cout_o[k];
        ov = ovf_o[k];
    endtask

    task automatic do_check(input int k, input bit s, input bit c,
                            input logic [31:0] a, input logic [31:0] b,
                            input int mode, input string tag);
        logic [31:0] r, er;
        bit co, ov, eco, eov, bok;
        int lat;
        model(width_of(k), s, c, a & mask_of(k), b & mask_of(k), er, eco, eov);
        run_op(k, s, c, a, b, mode, r, co, ov, lat, bok);
        chk({tag, "_result"},   r,          er);
        chk({tag, "_cout"},     32'(co),    32'(eco));
        chk({tag, "_overflow"}, 32'(ov),    32'(eov));
        chk({tag, "_latency"},  32'(lat),   32'(nch_of(k)));
        chk({tag, "_busy"},     32'(bok),   32'd1);
    endtask

    typedef struct {
        bit          s;
        bit          c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          co;
        bit          ov;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, a, b;
        bit co, ov, bok;
        int lat;

        // WIDTH=16 directed vectors with hand-computed expectations.
        tbl[0] = '{1'b0, 1'b0, 32'd15,    32'd12,    32'd27,    1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'hFFED,  32'd21,    32'h0002,  1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h7FFF,  32'h7FFF,  32'hFFFE,  1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'd1923,  32'd6421,  32'hEE6E,  1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h8000,  32'h0001,  32'h7FFF,  1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 32'hFFFF,  32'h0000,  32'h0000,  1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 32'd5,     32'd3,     32'h0001,  1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 32'h0000,  32'h0000,  32'hFFFF,  1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 32'h8000,  32'h8000,  32'h0000,  1'b1, 1'b1};

        start_i = '0;
        sub_i   = '0;
        cin_i   = '0;
        for (int k = 0; k < 4; k++) begin
            a_i[k] = '0;
            b_i[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_busy",     32'(busy_o[k]), 32'd0);
            chk("reset_done",     32'(done_o[k]), 32'd0);
            chk("reset_result",   get_res(k),     32'd0);
            chk("reset_cout",     32'(cout_o[k]), 32'd0);
            chk("reset_overflow", 32'(ovf_o[k]),  32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(0, tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].b, 0, r, co, ov, lat, bok);
            chk("tbl_result",   r,          tbl[i].r);
            chk("tbl_cout",     32'(co),    32'(tbl[i].co));
            chk("tbl_overflow", 32'(ov),    32'(tbl[i].ov));
            chk("tbl_latency",  32'(lat),   32'd4);
            chk("tbl_busy",     32'(bok),   32'd1);
            @(negedge clk);
            chk("tbl_idle_after_done", 32'({busy_o[0], done_o[0]}), 32'd0);
        end

        // Start pulsed mid-run with scrambled operands: ignored.
        do_check(0, 1'b0, 1'b0, 32'h1234, 32'h0F0F, 1, "start_in_run");
        @(negedge clk);
        chk("start_in_run_idle", 32'(busy_o[0]), 32'd0);
        chk("start_in_run_hold", get_res(0), 32'h2143);

        // Operands changed mid-run without start: result unaffected.
        do_check(0, 1'b1, 1'b1, 32'hA5C3, 32'h1234, 2, "operand_change");
        @(negedge clk);

        // Back-to-back: second start asserted in the DONE cycle.
        do_check(0, 1'b0, 1'b0, 32'd100, 32'd200, 0, "b2b_first");
        do_check(0, 1'b1, 1'b0, 32'd100, 32'd200, 0, "b2b_second");
        @(negedge clk);

        // Asynchronous reset two cycles into RUN.
        sub_i[0] = 1'b0; cin_i[0] = 1'b0;
        a_i[0] = 32'h1234; b_i[0] = 32'h1111;
        start_i[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",   32'(busy_o[0]), 32'd0);
        chk("async_rst_done",   32'(done_o[0]), 32'd0);
        chk("async_rst_result", get_res(0),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 1'b0, 1'b0, 32'd10, 32'd2, 0, r, co, ov, lat, bok);
        chk("post_rst_result",  r,        32'd12);
        chk("post_rst_latency", 32'(lat), 32'd4);
        @(negedge clk);

        // Randomized sweep across all parameter sets, with boundary operands mixed in.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (k == 0) ? 200 : 1000;
            for (int i = 0; i < n; i++) begin
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 7))
                    0: a = 32'hFFFF_FFFF;
                    1: b = 32'hFFFF_FFFF;
                    2: a = (k == 3) ? 32'h8000_0000 : 32'h0000_8000;
                    3: b = 32'd0;
                    default: ;
                endcase
                do_check(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         a, b, 0, "random");
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
